id_stage_pipe: RTL and testbench

- Parametrised decode stage: register file, operand read, immediate extension and jump-target formation.
- Holds an integrated ID/EX pipeline register with valid, stall and flush control.
- Sits between the IF/ID register and the execute stage; write-back from the final stage enters through the r3 write port.
- Generalises the earlier purely combinational decode: configurable data width and register count, four immediate modes, write-through bypass, and a registered output with stall refresh.

---
 rtl/id_pkg.sv | 19 +
 rtl/id_regfile.sv | 49 ++++
 rtl/id_stage_pipe.sv | 112 +++++++++++
 tb/tb_id_stage_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared constants for the decode stage: immediate-mode encodings and
// instruction field positions.
package id_pkg;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_BR   = 2'b10;
   localparam logic [1:0] EXT_LUI  = 2'b11;

   localparam int FIELD_W = 5;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 16;
   localparam int JIDX_LSB = 0;
   localparam int JIDX_W  = 26;

endpackage

// File: rtl/id_regfile.sv
// Two-read / one-write register file with write-through bypass and an
// optional hard-wired zero register. All entries clear on async reset.
module id_regfile
   import id_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [REG_AW-1:0] wa,
   input  logic              we,
   input  logic [DATA_W-1:0] wd,
   output logic              wr_fire
);

   localparam int NREG = 1 << REG_AW;

   logic [DATA_W-1:0] mem [NREG];

   // A write to register 0 is dropped when it is hard-wired to zero.
   assign wr_fire = we && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (wr_fire) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = mem[ra1];
      if (wr_fire && (wa == ra1)) rd1 = wd;
      if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
   end

   always_comb begin
      rd2 = mem[ra2];
      if (wr_fire && (wa == ra2)) rd2 = wd;
      if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand read, immediate extension, jump-target formation
// and the ID/EX pipeline register with stall refresh and flush.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] r3_addr,
   input  logic              r3_wr,
   input  logic [DATA_W-1:0] r3_din,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] i_PCplus4,
   input  logic [31:0]       instr,
   input  logic [1:0]        ext_mode,
   input  logic              stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_r1,
   output logic [DATA_W-1:0] ex_r2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_PCplus4,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [DATA_W-1:0] ex_jtarget
);

   logic [DATA_W-1:0] rd1, rd2, imm_ext, jtarget;
   logic [IMM_W-1:0]  imm16;
   logic              wr_fire;
   logic              unused_bits;

   assign imm16       = instr[IMM_LSB +: IMM_W];
   assign jtarget     = {i_PCplus4[DATA_W-1:28], instr[JIDX_LSB +: JIDX_W], 2'b00};
   assign unused_bits = ^{instr[31:26], i_PCplus4[27:0]};

   id_regfile #(
      .DATA_W   (DATA_W),
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra1     (instr[RS_LSB +: REG_AW]),
      .ra2     (instr[RT_LSB +: REG_AW]),
      .rd1     (rd1),
      .rd2     (rd2),
      .wa      (r3_addr),
      .we      (r3_wr),
      .wd      (r3_din),
      .wr_fire (wr_fire)
   );

   always_comb begin
      imm_ext = '0;
      case (ext_mode)
         EXT_ZERO: imm_ext = DATA_W'(imm16);
         EXT_SIGN: imm_ext = DATA_W'($signed(imm16));
         EXT_BR:   imm_ext = DATA_W'($signed(imm16)) << 2;
         EXT_LUI:  imm_ext = DATA_W'($signed({imm16, 16'h0000}));
         default:  imm_ext = '0;
      endcase
   end

   // Pipeline control, evaluated at each rising edge in priority order:
   // flush clears valid and payload; stall holds everything except that a
   // write-back hitting a held source register refreshes that operand;
   // otherwise the decoded instruction loads and ex_valid follows id_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_r1      <= '0;
         ex_r2      <= '0;
         ex_imm     <= '0;
         ex_PCplus4 <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_jtarget <= '0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_r1      <= '0;
         ex_r2      <= '0;
         ex_imm     <= '0;
         ex_PCplus4 <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_jtarget <= '0;
      end else if (stall) begin
         if (wr_fire && ex_valid) begin
            if (r3_addr == ex_rs[REG_AW-1:0]) ex_r1 <= r3_din;
            if (r3_addr == ex_rt[REG_AW-1:0]) ex_r2 <= r3_din;
         end
      end else begin
         ex_valid   <= id_valid;
         ex_r1      <= rd1;
         ex_r2      <= rd2;
         ex_imm     <= imm_ext;
         ex_PCplus4 <= i_PCplus4;
         ex_rs      <= instr[RS_LSB +: FIELD_W];
         ex_rt      <= instr[RT_LSB +: FIELD_W];
         ex_rd      <= instr[RD_LSB +: FIELD_W];
         ex_jtarget <= jtarget;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two configurations (32b/32 regs and 64b/16 regs)
// share one stimulus stream and are checked against a behavioural model.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  r3_addr;
   logic        r3_wr;
   logic [63:0] r3_din;
   logic        id_valid;
   logic [63:0] pc;
   logic [31:0] instr;
   logic [1:0]  ext_mode;
   logic        stall;
   logic        flush;
   logic        run;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic        a_valid, b_valid;
   logic [31:0] a_r1, a_r2, a_imm, a_pc, a_jt;
   logic [63:0] b_r1, b_r2, b_imm, b_pc, b_jt;
   logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;

   id_stage_pipe #(.DATA_W(32), .REG_AW(5), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .r3_addr(r3_addr), .r3_wr(r3_wr),
      .r3_din(r3_din[31:0]), .id_valid(id_valid), .i_PCplus4(pc[31:0]),
      .instr(instr), .ext_mode(ext_mode), .stall(stall), .flush(flush),
      .ex_valid(a_valid), .ex_r1(a_r1), .ex_r2(a_r2), .ex_imm(a_imm),
      .ex_PCplus4(a_pc), .ex_rs(a_rs), .ex_rt(a_rt), .ex_rd(a_rd),
      .ex_jtarget(a_jt)
   );

   id_stage_pipe #(.DATA_W(64), .REG_AW(4), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .r3_addr(r3_addr[3:0]), .r3_wr(r3_wr),
      .r3_din(r3_din), .id_valid(id_valid), .i_PCplus4(pc),
      .instr(instr), .ext_mode(ext_mode), .stall(stall), .flush(flush),
      .ex_valid(b_valid), .ex_r1(b_r1), .ex_r2(b_r2), .ex_imm(b_imm),
      .ex_PCplus4(b_pc), .ex_rs(b_rs), .ex_rt(b_rt), .ex_rd(b_rd),
      .ex_jtarget(b_jt)
   );

   // ---------------- behavioural model ----------------
   logic [63:0] mem_m [2][32];
   logic        m_valid [2];
   logic [63:0] m_r1 [2], m_r2 [2], m_imm [2], m_pc [2], m_jt [2];
   logic [4:0]  m_rs [2], m_rt [2], m_rd [2];

   function automatic int dw(input int c);
      return (c == 0) ? 32 : 64;
   endfunction

   function automatic int aw(input int c);
      return (c == 0) ? 5 : 4;
   endfunction

   function automatic logic [63:0] wmask(input int c);
      return (dw(c) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] ext(input logic [15:0] imm, input logic [1:0] m, input int c);
      logic [63:0] s, r;
      s = {{48{imm[15]}}, imm};
      case (m)
         2'd0:    r = {48'h0, imm};
         2'd1:    r = s;
         2'd2:    r = s << 2;
         default: r = {{32{imm[15]}}, imm, 16'h0000};
      endcase
      return r & wmask(c);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) mem_m[c][i] <= '0;
            m_valid[c] <= 1'b0;
            m_r1[c] <= '0; m_r2[c] <= '0; m_imm[c] <= '0; m_pc[c] <= '0; m_jt[c] <= '0;
            m_rs[c] <= '0; m_rt[c] <= '0; m_rd[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            int          amask, wa, ra1, ra2;
            logic        wok;
            logic [63:0] wd, pcm, v1, v2;
            amask = (1 << aw(c)) - 1;
            wa    = int'(r3_addr) & amask;
            wok   = r3_wr && (wa != 0);
            wd    = r3_din & wmask(c);
            pcm   = pc & wmask(c);
            ra1   = int'(instr[25:21]) & amask;
            ra2   = int'(instr[20:16]) & amask;
            v1    = (ra1 == 0) ? 64'h0 : ((wok && wa == ra1) ? wd : mem_m[c][ra1]);
            v2    = (ra2 == 0) ? 64'h0 : ((wok && wa == ra2) ? wd : mem_m[c][ra2]);
            if (flush) begin
               m_valid[c] <= 1'b0;
               m_r1[c] <= '0; m_r2[c] <= '0; m_imm[c] <= '0; m_pc[c] <= '0; m_jt[c] <= '0;
               m_rs[c] <= '0; m_rt[c] <= '0; m_rd[c] <= '0;
            end else if (stall) begin
               if (wok && m_valid[c]) begin
                  if (wa == (int'(m_rs[c]) & amask)) m_r1[c] <= wd;
                  if (wa == (int'(m_rt[c]) & amask)) m_r2[c] <= wd;
               end
            end else begin
               m_valid[c] <= id_valid;
               m_r1[c]    <= v1;
               m_r2[c]    <= v2;
               m_imm[c]   <= ext(instr[15:0], ext_mode, c);
               m_pc[c]    <= pcm;
               m_jt[c]    <= (pcm & ~64'h0FFF_FFFF) | ({38'h0, instr[25:0]} << 2);
               m_rs[c]    <= instr[25:21];
               m_rt[c]    <= instr[20:16];
               m_rd[c]    <= instr[15:11];
            end
            if (wok) mem_m[c][wa] <= wd;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("a.valid", {63'h0, a_valid}, {63'h0, m_valid[0]});
         chk("a.r1",    {32'h0, a_r1},    m_r1[0]);
         chk("a.r2",    {32'h0, a_r2},    m_r2[0]);
         chk("a.imm",   {32'h0, a_imm},   m_imm[0]);
         chk("a.pc",    {32'h0, a_pc},    m_pc[0]);
         chk("a.jt",    {32'h0, a_jt},    m_jt[0]);
         chk("a.rs",    {59'h0, a_rs},    {59'h0, m_rs[0]});
         chk("a.rt",    {59'h0, a_rt},    {59'h0, m_rt[0]});
         chk("a.rd",    {59'h0, a_rd},    {59'h0, m_rd[0]});
         chk("b.valid", {63'h0, b_valid}, {63'h0, m_valid[1]});
         chk("b.r1",    b_r1,             m_r1[1]);
         chk("b.r2",    b_r2,             m_r2[1]);
         chk("b.imm",   b_imm,            m_imm[1]);
         chk("b.pc",    b_pc,             m_pc[1]);
         chk("b.jt",    b_jt,             m_jt[1]);
         chk("b.rs",    {59'h0, b_rs},    {59'h0, m_rs[1]});
         chk("b.rt",    {59'h0, b_rt},    {59'h0, m_rt[1]});
         chk("b.rd",    {59'h0, b_rd},    {59'h0, m_rd[1]});
      end
   end

   // ---------------- driver ----------------
   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {6'h00, rs, rt, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r3_wr = 1'b0; r3_addr = '0; r3_din = '0; id_valid = 1'b0; pc = '0;
      instr = '0; ext_mode = 2'd0; stall = 1'b0; flush = 1'b0;
   endtask

   logic [63:0] imm_a_tab [4];
   logic [63:0] imm_b_tab [4];

   initial begin
      imm_a_tab = '{64'h0000_8004, 64'hFFFF_8004, 64'hFFFE_0010, 64'h8004_0000};
      imm_b_tab = '{64'h0000_0000_0000_8004, 64'hFFFF_FFFF_FFFF_8004,
                    64'hFFFF_FFFF_FFFE_0010, 64'hFFFF_FFFF_8004_0000};
      idle();
      run   = 1'b1;
      rst_n = 1'b0;
      step(); step();
      chk("rst.a_valid", {63'h0, a_valid}, 64'h0);
      chk("rst.b_jt",    b_jt,             64'h0);
      rst_n = 1'b1;
      step();

      // write r5, then read it back through rs
      r3_wr = 1'b1; r3_addr = 5'd5; r3_din = 64'h1234_5678;
      step();
      r3_wr = 1'b0; instr = mk(5'd5, 5'd0, 16'h0000); id_valid = 1'b1;
      step();
      chk("rd.a_r1",    {32'h0, a_r1},    64'h1234_5678);
      chk("rd.a_r2",    {32'h0, a_r2},    64'h0);
      chk("rd.a_valid", {63'h0, a_valid}, 64'h1);
      chk("rd.b_r1",    b_r1,             64'h1234_5678);

      // same-cycle write/read bypass
      r3_wr = 1'b1; r3_addr = 5'd7; r3_din = 64'hCAFE_0000; instr = mk(5'd7, 5'd0, 16'h0000);
      step();
      chk("byp.a_r1", {32'h0, a_r1}, 64'hCAFE_0000);
      chk("byp.b_r1", b_r1,          64'hCAFE_0000);

      // r0 ignores writes
      r3_addr = 5'd0; r3_din = 64'hFFFF_FFFF_FFFF_FFFF; instr = mk(5'd0, 5'd0, 16'h0000);
      step();
      chk("r0.a_r1_byp", {32'h0, a_r1}, 64'h0);
      r3_wr = 1'b0;
      step();
      chk("r0.b_r1", b_r1, 64'h0);

      // immediate modes
      instr = mk(5'd0, 5'd0, 16'h8004);
      for (int m = 0; m < 4; m++) begin
         ext_mode = 2'(m);
         step();
         chk("imm.a", {32'h0, a_imm}, imm_a_tab[m]);
         chk("imm.b", b_imm,          imm_b_tab[m]);
      end

      // jump target
      ext_mode = 2'd0; pc = 64'h4000_0010; instr = {6'h02, 26'h000_0100};
      step();
      chk("jt.a",    {32'h0, a_jt}, 64'h4000_0400);
      chk("jt.b",    b_jt,          64'h4000_0400);
      chk("jt.a_pc", {32'h0, a_pc}, 64'h4000_0010);

      // stall with refresh of rs=3
      pc = '0; ext_mode = 2'd1; instr = mk(5'd3, 5'd4, 16'h1234); id_valid = 1'b1;
      step();
      stall = 1'b1; r3_wr = 1'b1; r3_addr = 5'd3; r3_din = 64'hAA;
      instr = mk(5'd9, 5'd9, 16'hFFFF); id_valid = 1'b0;
      step(); step();
      chk("stl.a_r1",    {32'h0, a_r1},    64'hAA);
      chk("stl.a_rs",    {59'h0, a_rs},    64'd3);
      chk("stl.a_rt",    {59'h0, a_rt},    64'd4);
      chk("stl.a_valid", {63'h0, a_valid}, 64'h1);
      chk("stl.a_imm",   {32'h0, a_imm},   64'h1234);
      chk("stl.b_r1",    b_r1,             64'hAA);

      // flush beats stall
      r3_wr = 1'b0; flush = 1'b1;
      step();
      chk("fl.a_valid", {63'h0, a_valid}, 64'h0);
      chk("fl.a_r1",    {32'h0, a_r1},    64'h0);
      chk("fl.a_rs",    {59'h0, a_rs},    64'h0);
      chk("fl.b_imm",   b_imm,            64'h0);

      // r17 aliases r1 in the 16-register configuration
      flush = 1'b0; stall = 1'b0;
      r3_wr = 1'b1; r3_addr = 5'd17; r3_din = 64'h8000_0000_0000_0005;
      instr = mk(5'd17, 5'd1, 16'h0F00); id_valid = 1'b0;
      step();
      chk("al.a_r1",    {32'h0, a_r1},    64'h5);
      chk("al.a_r2",    {32'h0, a_r2},    64'h0);
      chk("al.b_r2",    b_r2,             64'h8000_0000_0000_0005);
      chk("al.a_valid", {63'h0, a_valid}, 64'h0);

      // stall with ex_valid=0: no refresh
      stall = 1'b1; r3_addr = 5'd1; r3_din = 64'h77;
      step();
      chk("nv.a_r2", {32'h0, a_r2}, 64'h0);

      // refresh of rt only
      stall = 1'b0; r3_wr = 1'b0; instr = mk(5'd2, 5'd1, 16'h0000); id_valid = 1'b1;
      step();
      stall = 1'b1; r3_wr = 1'b1; r3_addr = 5'd1; r3_din = 64'h99;
      step();
      chk("rt.a_r2", {32'h0, a_r2}, 64'h99);
      chk("rt.a_r1", {32'h0, a_r1}, 64'h0);

      // reset asserted mid-stall clears state at once
      #2 rst_n = 1'b0;
      #1;
      chk("mr.a_r2",    {32'h0, a_r2},    64'h0);
      chk("mr.b_valid", {63'h0, b_valid}, 64'h0);
      step();
      idle();
      rst_n = 1'b1;
      step();
      instr = mk(5'd5, 5'd1, 16'h0000); id_valid = 1'b1;
      step();
      chk("mr.a_r1_after", {32'h0, a_r1}, 64'h0);
      chk("mr.b_r2_after", b_r2,          64'h0);

      idle();
      step(); step();
      @(negedge clk);
      #1;
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
